// File: rtl/punc_control.sv
`default_nettype none
// ============================================================================
// Module   : punc_control
// Purpose  : PUnC LC3 control unit; sequences INIT/FETCH/DECODE/EXECUTE/HALT
//            and drives every datapath select and enable.
// Revision : 1.0
// ============================================================================
module punc_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ir,
    input  logic             n,
    input  logic             z,
    input  logic             p,
    output logic             ir_ld,
    output logic             pc_clr,
    output logic             pc_inc,
    output logic             pc_ld,
    output logic [1:0]       pc_ld_data_sel,
    output logic [1:0]       mem_r_addr_sel,
    output logic             mem_w_addr_sel,
    output logic             mem_w_en,
    output logic             rf_r0_addr_sel,
    output logic             rf_r1_addr_sel,
    output logic             rf_w_addr_sel,
    output logic [1:0]       rf_w_data_sel,
    output logic             rf_w_en,
    output logic [1:0]       alu_sel,
    output logic             alu_b_sel,
    output logic             cond_ld,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam int c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        ST_INIT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [3:0] c_OP_BR  = 4'b0000;
    localparam logic [3:0] c_OP_ADD = 4'b0001;
    localparam logic [3:0] c_OP_LD  = 4'b0010;
    localparam logic [3:0] c_OP_ST  = 4'b0011;
    localparam logic [3:0] c_OP_JSR = 4'b0100;
    localparam logic [3:0] c_OP_AND = 4'b0101;
    localparam logic [3:0] c_OP_LDR = 4'b0110;
    localparam logic [3:0] c_OP_STR = 4'b0111;
    localparam logic [3:0] c_OP_NOT = 4'b1001;
    localparam logic [3:0] c_OP_JMP = 4'b1100;
    localparam logic [3:0] c_OP_LEA = 4'b1110;

    typedef struct packed {
        logic       ir_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic       pc_ld;
        logic [1:0] pc_ld_data_sel;
        logic [1:0] mem_r_addr_sel;
        logic       mem_w_addr_sel;
        logic       mem_w_en;
        logic       rf_r0_addr_sel;
        logic       rf_r1_addr_sel;
        logic       rf_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_en;
        logic [1:0] alu_sel;
        logic       alu_b_sel;
        logic       cond_ld;
        logic       halted;
    } ctrl_t;

    state_t            r_state_q;
    state_t            w_state_d;
    ctrl_t             r_ctrl_q;
    ctrl_t             w_ctrl_d;
    logic [CNT_W-1:0]  r_count_q;
    logic [CNT_W-1:0]  w_count_d;
    logic              w_unsupported;
    logic              w_unused_ir;

    // Control word for the state about to be entered; registering it keeps
    // every output glitch-free while still matching the Moore decode.
    function automatic ctrl_t decode(input state_t st, input logic [15:0] instr,
                                     input logic nn, input logic zz, input logic pp);
        ctrl_t c;
        c = '0;
        case (st)
            ST_INIT:  c.pc_clr = 1'b1;
            ST_FETCH: begin
                c.ir_ld  = 1'b1;
                c.pc_inc = 1'b1;
            end
            ST_EXECUTE: begin
                case (instr[15:12])
                    c_OP_ADD, c_OP_AND: begin
                        c.rf_w_en   = 1'b1;
                        c.cond_ld   = 1'b1;
                        c.alu_sel   = (instr[15:12] == c_OP_AND) ? 2'd1 : 2'd0;
                        c.alu_b_sel = instr[5];
                    end
                    c_OP_NOT: begin
                        c.rf_w_en = 1'b1;
                        c.cond_ld = 1'b1;
                        c.alu_sel = 2'd2;
                    end
                    c_OP_BR: c.pc_ld = (instr[11] & nn) | (instr[10] & zz) | (instr[9] & pp);
                    c_OP_JMP: begin
                        c.pc_ld          = 1'b1;
                        c.pc_ld_data_sel = 2'd1;
                    end
                    c_OP_JSR: begin
                        c.rf_w_en        = 1'b1;
                        c.rf_w_addr_sel  = 1'b1;
                        c.rf_w_data_sel  = 2'd2;
                        c.pc_ld          = 1'b1;
                        c.pc_ld_data_sel = instr[11] ? 2'd2 : 2'd1;
                    end
                    c_OP_LD, c_OP_LDR: begin
                        c.mem_r_addr_sel = (instr[15:12] == c_OP_LDR) ? 2'd2 : 2'd1;
                        c.rf_w_data_sel  = 2'd1;
                        c.rf_w_en        = 1'b1;
                        c.cond_ld        = 1'b1;
                    end
                    c_OP_LEA: begin
                        c.rf_w_data_sel = 2'd3;
                        c.rf_w_en       = 1'b1;
                    end
                    c_OP_ST: begin
                        c.rf_r0_addr_sel = 1'b1;
                        c.mem_w_en       = 1'b1;
                    end
                    c_OP_STR: begin
                        c.rf_r0_addr_sel = 1'b1;
                        c.rf_r1_addr_sel = 1'b1;
                        c.mem_w_addr_sel = 1'b1;
                        c.mem_w_en       = 1'b1;
                    end
                    default: c = '0;
                endcase
            end
            ST_HALT: c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // TRAP is treated as HALT; RTI, LDI, STI and the reserved opcode stop the core.
    assign w_unsupported = ir[15:12] inside {4'b1111, 4'b1000, 4'b1010, 4'b1011, 4'b1101};
    assign w_unused_ir   = ^{ir[8:6], ir[4:0]};

    always_comb begin
        w_state_d = r_state_q;
        w_count_d = r_count_q;
        case (r_state_q)
            ST_INIT:    w_state_d = ST_FETCH;
            ST_FETCH:   w_state_d = ST_DECODE;
            ST_DECODE:  w_state_d = w_unsupported ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE: begin
                w_state_d = ST_FETCH;
                w_count_d = r_count_q + CNT_W'(1);
            end
            ST_HALT:    w_state_d = ST_HALT;
            default:    w_state_d = ST_INIT;
        endcase
        w_ctrl_d = decode(w_state_d, ir, n, z, p);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_INIT;
            r_ctrl_q  <= decode(ST_INIT, ir, n, z, p);
            r_count_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_ctrl_q  <= w_ctrl_d;
            r_count_q <= w_count_d;
        end
    end

    assign ir_ld          = r_ctrl_q.ir_ld;
    assign pc_clr         = r_ctrl_q.pc_clr;
    assign pc_inc         = r_ctrl_q.pc_inc;
    assign pc_ld          = r_ctrl_q.pc_ld;
    assign pc_ld_data_sel = r_ctrl_q.pc_ld_data_sel;
    assign mem_r_addr_sel = r_ctrl_q.mem_r_addr_sel;
    assign mem_w_addr_sel = r_ctrl_q.mem_w_addr_sel;
    assign mem_w_en       = r_ctrl_q.mem_w_en;
    assign rf_r0_addr_sel = r_ctrl_q.rf_r0_addr_sel;
    assign rf_r1_addr_sel = r_ctrl_q.rf_r1_addr_sel;
    assign rf_w_addr_sel  = r_ctrl_q.rf_w_addr_sel;
    assign rf_w_data_sel  = r_ctrl_q.rf_w_data_sel;
    assign rf_w_en        = r_ctrl_q.rf_w_en;
    assign alu_sel        = r_ctrl_q.alu_sel;
    assign alu_b_sel      = r_ctrl_q.alu_b_sel;
    assign cond_ld        = r_ctrl_q.cond_ld;
    assign halted         = r_ctrl_q.halted;
    assign instr_count    = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_punc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_punc_control
// Purpose  : Directed self-checking bench for punc_control.
// Revision : 1.0
// ============================================================================
module tb_punc_control;

    // Narrow counter so the wrap-around case is reachable in a short run.
    localparam int CNT_W = 8;

    typedef struct packed {
        logic       ir_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic       pc_ld;
        logic [1:0] pc_ld_data_sel;
        logic [1:0] mem_r_addr_sel;
        logic       mem_w_addr_sel;
        logic       mem_w_en;
        logic       rf_r0_addr_sel;
        logic       rf_r1_addr_sel;
        logic       rf_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_en;
        logic [1:0] alu_sel;
        logic       alu_b_sel;
        logic       cond_ld;
        logic       halted;
    } ctrl_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      ir;
    logic             n, z, p;
    logic             ir_ld, pc_clr, pc_inc, pc_ld;
    logic [1:0]       pc_ld_data_sel, mem_r_addr_sel;
    logic             mem_w_addr_sel, mem_w_en;
    logic             rf_r0_addr_sel, rf_r1_addr_sel, rf_w_addr_sel;
    logic [1:0]       rf_w_data_sel;
    logic             rf_w_en;
    logic [1:0]       alu_sel;
    logic             alu_b_sel, cond_ld, halted;
    logic [CNT_W-1:0] instr_count;

    ctrl_t            obs;
    ctrl_t            e;
    ctrl_t            c_fetch;
    logic [CNT_W-1:0] exp_count;
    int               checks = 0;
    int               errors = 0;
    logic [15:0]      unsup [4];

    always #5 clk = ~clk;

    punc_control #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .ir             (ir),
        .n              (n),
        .z              (z),
        .p              (p),
        .ir_ld          (ir_ld),
        .pc_clr         (pc_clr),
        .pc_inc         (pc_inc),
        .pc_ld          (pc_ld),
        .pc_ld_data_sel (pc_ld_data_sel),
        .mem_r_addr_sel (mem_r_addr_sel),
        .mem_w_addr_sel (mem_w_addr_sel),
        .mem_w_en       (mem_w_en),
        .rf_r0_addr_sel (rf_r0_addr_sel),
        .rf_r1_addr_sel (rf_r1_addr_sel),
        .rf_w_addr_sel  (rf_w_addr_sel),
        .rf_w_data_sel  (rf_w_data_sel),
        .rf_w_en        (rf_w_en),
        .alu_sel        (alu_sel),
        .alu_b_sel      (alu_b_sel),
        .cond_ld        (cond_ld),
        .halted         (halted),
        .instr_count    (instr_count)
    );

    always_comb obs = {ir_ld, pc_clr, pc_inc, pc_ld, pc_ld_data_sel, mem_r_addr_sel,
                       mem_w_addr_sel, mem_w_en, rf_r0_addr_sel, rf_r1_addr_sel,
                       rf_w_addr_sel, rf_w_data_sel, rf_w_en, alu_sel, alu_b_sel,
                       cond_ld, halted};

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_ctrl(input string tag, input ctrl_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%06h expected=%06h", tag, obs, exp);
        end
    endtask

    task automatic check_count(input string tag, input logic [CNT_W-1:0] exp);
        checks++;
        assert (instr_count === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, instr_count, exp);
        end
    endtask

    // Called during FETCH: present the instruction, advance to EXECUTE.
    task automatic to_execute(input logic [15:0] v, input logic [2:0] nzp);
        ir = v;
        {n, z, p} = nzp;
        tick();
        tick();
    endtask

    // Called during EXECUTE: advance to the next FETCH and check the retire.
    task automatic retire(input string tag);
        tick();
        exp_count++;
        check_count(tag, exp_count);
        check_ctrl({tag, "_fetch"}, c_fetch);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        exp_count = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        c_fetch = '0;
        c_fetch.ir_ld  = 1'b1;
        c_fetch.pc_inc = 1'b1;
        unsup[0] = 16'h8000;
        unsup[1] = 16'hA000;
        unsup[2] = 16'hB000;
        unsup[3] = 16'hD000;
        exp_count = '0;
        rst = 1'b1;
        ir  = 16'h0000;
        {n, z, p} = 3'b000;

        // Reset held for two edges; the cycle in reset is INIT.
        tick();
        tick();
        e = '0; e.pc_clr = 1'b1;
        check_ctrl("reset_init", e);
        check_count("reset_count", '0);
        rst = 1'b0;
        tick();
        check_ctrl("reset_fetch", c_fetch);
        check_count("reset_fetch_count", '0);

        // ADD R1,R1,#1
        ir = 16'h1261;
        tick();
        check_ctrl("add_decode", '0);
        tick();
        e = '0; e.rf_w_en = 1'b1; e.cond_ld = 1'b1; e.alu_b_sel = 1'b1;
        check_ctrl("add_imm_exec", e);
        check_count("add_exec_count", '0);
        retire("add_imm");

        // AND R0,R1,R2 (register form)
        to_execute(16'h5042, 3'b000);
        e = '0; e.rf_w_en = 1'b1; e.cond_ld = 1'b1; e.alu_sel = 2'd1;
        check_ctrl("and_reg_exec", e);
        retire("and_reg");

        // NOT ignores ir[5] for the B operand select
        to_execute(16'h927F, 3'b000);
        e = '0; e.rf_w_en = 1'b1; e.cond_ld = 1'b1; e.alu_sel = 2'd2;
        check_ctrl("not_exec", e);
        retire("not");

        to_execute(16'h0402, 3'b010);
        e = '0; e.pc_ld = 1'b1;
        check_ctrl("brz_taken", e);
        retire("brz_taken");

        to_execute(16'h0402, 3'b100);
        check_ctrl("brz_not_taken", '0);
        retire("brz_not_taken");

        to_execute(16'h0000, 3'b111);
        check_ctrl("br_nzp000", '0);
        retire("br_nzp000");

        to_execute(16'h41C0, 3'b000);
        e = '0; e.rf_w_en = 1'b1; e.rf_w_addr_sel = 1'b1; e.rf_w_data_sel = 2'd2;
        e.pc_ld = 1'b1; e.pc_ld_data_sel = 2'd1;
        check_ctrl("jsrr_r7", e);
        retire("jsrr");

        to_execute(16'h4800, 3'b000);
        e.pc_ld_data_sel = 2'd2;
        check_ctrl("jsr_off11", e);
        retire("jsr");

        to_execute(16'hC1C0, 3'b000);
        e = '0; e.pc_ld = 1'b1; e.pc_ld_data_sel = 2'd1;
        check_ctrl("jmp", e);
        retire("jmp");

        to_execute(16'h7442, 3'b000);
        e = '0; e.mem_w_en = 1'b1; e.mem_w_addr_sel = 1'b1;
        e.rf_r0_addr_sel = 1'b1; e.rf_r1_addr_sel = 1'b1;
        check_ctrl("str", e);
        retire("str");

        to_execute(16'h3003, 3'b000);
        e = '0; e.mem_w_en = 1'b1; e.rf_r0_addr_sel = 1'b1;
        check_ctrl("st", e);
        retire("st");

        to_execute(16'h2201, 3'b000);
        e = '0; e.mem_r_addr_sel = 2'd1; e.rf_w_data_sel = 2'd1;
        e.rf_w_en = 1'b1; e.cond_ld = 1'b1;
        check_ctrl("ld", e);
        retire("ld");

        to_execute(16'h6281, 3'b000);
        e.mem_r_addr_sel = 2'd2;
        check_ctrl("ldr", e);
        retire("ldr");

        to_execute(16'hE201, 3'b000);
        e = '0; e.rf_w_data_sel = 2'd3; e.rf_w_en = 1'b1;
        check_ctrl("lea", e);
        retire("lea");

        // TRAP x25: halts after DECODE and stays there with the count frozen.
        to_execute(16'hF025, 3'b000);
        e = '0; e.halted = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check_ctrl("halt_hold", e);
            check_count("halt_count_frozen", exp_count);
            tick();
        end
        rst = 1'b1;
        tick();
        e = '0; e.pc_clr = 1'b1;
        check_ctrl("halt_reset_init", e);
        check_count("halt_reset_count", '0);
        rst = 1'b0;
        tick();
        exp_count = '0;

        // Unsupported opcodes also halt.
        for (int i = 0; i < 4; i++) begin
            to_execute(unsup[i], 3'b000);
            e = '0; e.halted = 1'b1;
            check_ctrl("unsupported_halt", e);
            do_reset();
        end

        // Reset asserted during EXECUTE of ST.
        to_execute(16'h1261, 3'b000);
        retire("pre_st_add");
        to_execute(16'h3003, 3'b000);
        rst = 1'b1;
        tick();
        e = '0; e.pc_clr = 1'b1;
        check_ctrl("st_mid_reset_init", e);
        check_count("st_mid_reset_count", '0);
        rst = 1'b0;
        tick();
        exp_count = '0;

        // Retire 2^CNT_W - 1 instructions, then one more wraps to zero.
        for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
            to_execute(16'h1261, 3'b000);
            tick();
        end
        exp_count = '1;
        check_count("count_max", exp_count);
        to_execute(16'h1261, 3'b000);
        retire("count_wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
